// File: rtl/clink_pkg.sv
// Shared constants for the Camera Link base-configuration X-channel transmitter:
// slot timing, clock-lane pattern, FSM states and the 28-bit word to lane bit map.
package clink_pkg;

    localparam int         SLOTS       = 7;
    localparam logic [2:0] SLOT_LAST   = 3'(SLOTS - 1);
    localparam logic [6:0] CLK_PATTERN = 7'b1100011;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 28;

    // Word layout: [7:0]=A, [15:8]=B, [23:16]=C, then the three sync flags and a spare 0.
    localparam int unsigned W_LVAL = 24;
    localparam int unsigned W_FVAL = 25;
    localparam int unsigned W_DVAL = 26;
    localparam int unsigned W_ZERO = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LINE,
        ST_HBLANK,
        ST_POST
    } state_t;

    // Element [s] is the word bit driven on that lane in slot s.
    typedef logic [SLOTS-1:0][4:0] lane_map_t;

    localparam lane_map_t X0_MAP = {5'd8,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0};
    localparam lane_map_t X1_MAP = {5'd17, 5'd16, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9};
    localparam lane_map_t X2_MAP = {5'(W_DVAL), 5'(W_FVAL), 5'(W_LVAL),
                                    5'd21, 5'd20, 5'd19, 5'd18};
    localparam lane_map_t X3_MAP = {5'(W_ZERO), 5'd23, 5'd22, 5'd15, 5'd14, 5'd7, 5'd6};

endpackage

// File: rtl/clink_tx_serializer.sv
// 7:1 serializer: slot counter, 28-bit word holding register and registered
// clock/data lane outputs. A new word is taken on the slot 6 -> 0 transition.
module clink_tx_serializer
    import clink_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word,
    output logic              load,
    output logic [2:0]        slot,
    output logic              lane_clk,
    output logic [3:0]        lanes
);

    // slot is the slot the output registers present after the coming edge.
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] src;

    assign load = (slot == 3'd0);
    assign src  = load ? word : word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= 3'd0;
            word_q   <= '0;
            lane_clk <= 1'b0;
            lanes    <= 4'd0;
        end else begin
            slot     <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
            lane_clk <= CLK_PATTERN[SLOT_LAST - slot];
            lanes    <= {src[X3_MAP[slot]], src[X2_MAP[slot]],
                         src[X1_MAP[slot]], src[X0_MAP[slot]]};
            if (load) begin
                word_q <= word;
            end
        end
    end

endmodule

// File: rtl/clink_x_tx.sv
// Camera Link X-channel frame generator: trigger handling, frame FSM and pixel source.
// Define CLINK_TX_LFSR_EN for LFSR pixel data instead of the default pixel counter.
module clink_x_tx
    import clink_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 32,
    parameter int F_PORCH  = 4
) (
    input  logic clk_x7,
    input  logic clk_x7_reset,
    input  logic trigger,
    input  logic clink_en,
    output logic clink_X_clk,
    output logic clink_X_data_0,
    output logic clink_X_data_1,
    output logic clink_X_data_2,
    output logic clink_X_data_3,
    output logic image_end,
    output logic busy,
    output logic trig_overrun
);

`ifdef CLINK_TX_LFSR_EN
    localparam logic [PIX_W-1:0] PIX_SEED = 24'h000001;

    function automatic logic [PIX_W-1:0] pix_step(input logic [PIX_W-1:0] p);
        return {p[22:0], p[23] ^ p[22] ^ p[21] ^ p[16]};
    endfunction
`else
    localparam logic [PIX_W-1:0] PIX_SEED = 24'h000000;

    function automatic logic [PIX_W-1:0] pix_step(input logic [PIX_W-1:0] p);
        return p + 24'd1;
    endfunction
`endif

    localparam logic [11:0] HA_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] HB_LAST = 12'(H_BLANK - 1);
    localparam logic [11:0] VA_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] FP_LAST = 12'(F_PORCH - 1);

    // state/cnt/line describe the word currently on the lanes.
    state_t             state, state_nxt;
    logic [11:0]        cnt, cnt_nxt;
    logic [11:0]        line, line_nxt;
    logic               pending;
    logic [PIX_W-1:0]   pix;
    logic [WORD_W-1:0]  word;
    logic               load;
    logic [2:0]         slot;
    logic [3:0]         lanes;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 12'd1;
        line_nxt  = line;
        case (state)
            ST_IDLE: begin
                cnt_nxt = 12'd0;
                if (pending) begin
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (cnt == FP_LAST) begin
                    state_nxt = ST_LINE;
                    cnt_nxt   = 12'd0;
                    line_nxt  = 12'd0;
                end
            end
            ST_LINE: begin
                if (cnt == HA_LAST) begin
                    cnt_nxt   = 12'd0;
                    state_nxt = (line == VA_LAST) ? ST_POST : ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                if (cnt == HB_LAST) begin
                    state_nxt = ST_LINE;
                    cnt_nxt   = 12'd0;
                    line_nxt  = line + 12'd1;
                end
            end
            ST_POST: begin
                if (cnt == FP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 12'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 12'd0;
            end
        endcase
    end

    always_comb begin
        word = '0;
        if (state_nxt != ST_IDLE) begin
            word[W_FVAL] = 1'b1;
        end
        if (state_nxt == ST_LINE) begin
            word[W_LVAL]     = 1'b1;
            word[W_DVAL]     = 1'b1;
            word[PIX_W-1:0]  = pix;
        end
    end

    always_ff @(posedge clk_x7) begin
        if (clk_x7_reset) begin
            state        <= ST_IDLE;
            cnt          <= 12'd0;
            line         <= 12'd0;
            pending      <= 1'b0;
            pix          <= '0;
            image_end    <= 1'b0;
            busy         <= 1'b0;
            trig_overrun <= 1'b0;
        end else begin
            image_end <= (slot == SLOT_LAST) && (state == ST_POST) && (cnt == FP_LAST);
            if (load) begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                line  <= line_nxt;
                if (state == ST_IDLE && state_nxt == ST_PRE) begin
                    pending <= 1'b0;
                    pix     <= PIX_SEED;
                end else if (state_nxt == ST_LINE) begin
                    pix <= pix_step(pix);
                end
                if (state == ST_POST && state_nxt == ST_IDLE) begin
                    busy <= 1'b0;
                end
            end
            // busy covers the latched-but-not-started window, so a second request there is an overrun too.
            if (trigger) begin
                if (busy) begin
                    trig_overrun <= 1'b1;
                end else if (clink_en) begin
                    pending <= 1'b1;
                    busy    <= 1'b1;
                end
            end
        end
    end

    clink_tx_serializer u_ser (
        .clk      (clk_x7),
        .rst      (clk_x7_reset),
        .word     (word),
        .load     (load),
        .slot     (slot),
        .lane_clk (clink_X_clk),
        .lanes    (lanes)
    );

    assign clink_X_data_0 = lanes[0];
    assign clink_X_data_1 = lanes[1];
    assign clink_X_data_2 = lanes[2];
    assign clink_X_data_3 = lanes[3];

endmodule
